// File: rtl/tree_node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_pkg
// Description : Shared definitions for module-tree nodes. Holds the default
//               sizing constants and the fan-in collector state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_node_pkg;

    localparam int C_DEF_NUM_CHILD = 5;
    localparam int C_DEF_DATA_W    = 32;
    localparam int C_DEF_IDX_W     = 3;
    localparam int C_DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search begins at ptr
//               and wraps modulo NUM_REQ; the first requester found wins.
// Ports       : req         - request vector
//               ptr         - highest-priority position (must be < NUM_REQ)
//               enable      - grants are suppressed when low
//               grant       - one-hot grant (or zero)
//               grant_idx   - encoded index of the granted requester
//               grant_valid - a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0] w_pos;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            // Decode the rotated position against each requester so that no
            // variable bit-select on req is needed.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enable && !grant_valid && req[i] && (w_pos == (IDX_W+1)'(i))) begin
                    grant[i]    = 1'b1;
                    grant_idx   = IDX_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hier_fanin_collector.sv
`default_nettype none
// ============================================================================
// Module      : hier_fanin_collector
// Description : Fan-in node of the module tree. Round-robin merges the result
//               streams of NUM_CHILD children into one registered upstream
//               stream tagged with the source index, tracks each child's
//               final beat, and flags when every child has finished.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               clear        - synchronous flush / restart of a round
//               child_*      - per-child valid/ready/last/data streams
//               up_*         - registered upstream stream with index tag
//               done_mask    - children whose last beat was accepted
//               all_done     - round complete
//               beat_cnt     - saturating count of upstream handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module hier_fanin_collector
    import tree_node_pkg::*;
#(
    parameter int NUM_CHILD = C_DEF_NUM_CHILD,
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int IDX_W     = C_DEF_IDX_W,
    parameter int CNT_W     = C_DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD-1:0]        child_last,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        up_valid,
    output logic [DATA_W-1:0]           up_data,
    output logic [IDX_W-1:0]            up_idx,
    output logic                        up_last,
    input  logic                        up_ready,
    output logic [NUM_CHILD-1:0]        done_mask,
    output logic                        all_done,
    output logic [CNT_W-1:0]            beat_cnt
);

    localparam logic [NUM_CHILD-1:0] C_ALL_CHILD = '1;
    localparam logic [CNT_W-1:0]     C_CNT_MAX   = '1;

    collector_state_t     r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_up_valid;
    logic [DATA_W-1:0]    r_up_data;
    logic [IDX_W-1:0]     r_up_idx;
    logic                 r_up_last;
    logic [NUM_CHILD-1:0] r_done_mask;
    logic [CNT_W-1:0]     r_beat_cnt;

    logic                 w_slot_free;
    logic                 w_arb_en;
    logic                 w_up_fire;
    logic [NUM_CHILD-1:0] w_req;
    logic [NUM_CHILD-1:0] w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_grant_valid;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_sel_last;

    assign w_slot_free = !r_up_valid || up_ready;
    assign w_arb_en    = w_slot_free && (r_state != ST_DONE) && !clear;
    assign w_up_fire   = r_up_valid && up_ready;
    // A child that has delivered its last beat is ignored until clear.
    assign w_req       = child_valid & ~r_done_mask;

    rr_arbiter #(
        .NUM_REQ (NUM_CHILD),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (w_req),
        .ptr         (r_ptr),
        .enable      (w_arb_en),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    // Registers are forced to idle during reset, but the grant is still
    // combinational, so ready is gated explicitly to stay low in reset.
    assign child_ready = w_grant & {NUM_CHILD{rst_n}};

    assign w_next_ptr = (w_grant_idx == IDX_W'(NUM_CHILD-1)) ? '0 : w_grant_idx + 1'b1;

    // One-hot AND-OR select of the granted child's payload and last flag.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (w_grant[i]) begin
                w_sel_data = child_data[i*DATA_W +: DATA_W];
                w_sel_last = child_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_up_valid  <= 1'b0;
            r_up_data   <= '0;
            r_up_idx    <= '0;
            r_up_last   <= 1'b0;
            r_done_mask <= '0;
            r_beat_cnt  <= '0;
        end else if (clear) begin
            // Any beat still waiting upstream is dropped.
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_up_valid  <= 1'b0;
            r_done_mask <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_up_fire && (r_beat_cnt != C_CNT_MAX)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end

            // The output register reloads in the same cycle it is accepted,
            // giving one beat per cycle with no bubble.
            if (w_slot_free) begin
                if (w_grant_valid) begin
                    r_up_valid <= 1'b1;
                    r_up_data  <= w_sel_data;
                    r_up_idx   <= w_grant_idx;
                    r_up_last  <= w_sel_last;
                    r_ptr      <= w_next_ptr;
                    if (w_sel_last) begin
                        r_done_mask <= r_done_mask | w_grant;
                    end
                end else begin
                    r_up_valid <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (r_done_mask == C_ALL_CHILD) begin
                        r_state <= r_up_valid ? ST_DRAIN : ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if ((r_done_mask == C_ALL_CHILD) && !r_up_valid) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign up_valid  = r_up_valid;
    assign up_data   = r_up_data;
    assign up_idx    = r_up_idx;
    assign up_last   = r_up_last;
    assign done_mask = r_done_mask;
    assign all_done  = (r_state == ST_DONE);
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hier_fanin_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_hier_fanin_collector
// Description : Self-checking bench for hier_fanin_collector (5 children,
//               32-bit data, 4-bit beat counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hier_fanin_collector;
    import tree_node_pkg::*;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [N-1:0]  child_valid;
    logic [N-1:0]  child_last;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]  child_ready;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic [IW-1:0] up_idx;
    logic          up_last;
    logic          up_ready;
    logic [N-1:0]  done_mask;
    logic          all_done;
    logic [CW-1:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    hier_fanin_collector #(
        .NUM_CHILD (N),
        .DATA_W    (DW),
        .IDX_W     (IW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .child_valid (child_valid),
        .child_last  (child_last),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_idx      (up_idx),
        .up_last     (up_last),
        .up_ready    (up_ready),
        .done_mask   (done_mask),
        .all_done    (all_done),
        .beat_cnt    (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  valid;
        logic          rdy;
        logic [N-1:0]  exp_ready;
        logic          exp_vld;
        logic [IW-1:0] exp_idx;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        child_data[i*DW +: DW] = v;
    endtask

    task automatic do_clear();
        clear       = 1'b1;
        child_valid = '1;
        child_last  = '0;
        #1;
        check("ready_during_clear", child_ready, 0);
        tick();
        clear       = 1'b0;
        child_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem[N];
        int sent[N];
        int seq[9];
        int g;
        logic exp_l;
        logic [N-1:0] exp_done;
        logic seen_drain;

        rst_n = 1'b0; clear = 1'b0; up_ready = 1'b0;
        child_valid = '1; child_last = '0; child_data = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_ready", child_ready, 0);
        check("rst_up_valid", up_valid, 0);
        check("rst_done_mask", done_mask, 0);
        check("rst_all_done", all_done, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        #1 rst_n = 1'b1;

        // ---------------- reset mid-stream ----------------
        child_valid = 5'b00001;
        set_data(0, 32'hDEAD);
        tick();
        check("pre_rst_up_valid", up_valid, 1);
        check("pre_rst_up_data", up_data, 32'hDEAD);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_up_valid", up_valid, 0);
        check("async_rst_up_data", up_data, 0);
        check("async_rst_up_idx", up_idx, 0);
        check("async_rst_up_last", up_last, 0);
        check("async_rst_ready", child_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        child_valid = '1;
        #1;
        check("post_rst_first_grant", child_ready, 5'b00001);
        tick();
        check("post_rst_up_idx", up_idx, 0);
        child_valid = '0;
        do_clear();

        // ---------------- table-driven round robin ----------------
        for (int i = 0; i < N; i++) set_data(i, 32'hA000_0000 + i);
        for (int k = 0; k <= 10; k++) begin
            vecs[k].valid     = 5'b11111;
            vecs[k].rdy       = 1'b1;
            vecs[k].exp_ready = 5'b00001 << (k % 5);
            vecs[k].exp_vld   = 1'b1;
            vecs[k].exp_idx   = IW'(k % 5);
            vecs[k].exp_cnt   = CW'(k);
        end
        vecs[11] = '{valid: 5'b10100, rdy: 1'b1, exp_ready: 5'b00100, exp_vld: 1'b1, exp_idx: 3'd2, exp_cnt: 4'd11};
        vecs[12] = '{valid: 5'b10100, rdy: 1'b1, exp_ready: 5'b10000, exp_vld: 1'b1, exp_idx: 3'd4, exp_cnt: 4'd12};
        vecs[13] = '{valid: 5'b00011, rdy: 1'b1, exp_ready: 5'b00001, exp_vld: 1'b1, exp_idx: 3'd0, exp_cnt: 4'd13};
        vecs[14] = '{valid: 5'b00000, rdy: 1'b1, exp_ready: 5'b00000, exp_vld: 1'b0, exp_idx: 3'd0, exp_cnt: 4'd14};
        vecs[15] = '{valid: 5'b00010, rdy: 1'b1, exp_ready: 5'b00010, exp_vld: 1'b1, exp_idx: 3'd1, exp_cnt: 4'd14};
        for (int k = 0; k < 16; k++) begin
            child_valid = vecs[k].valid;
            up_ready    = vecs[k].rdy;
            #1;
            check($sformatf("vec%0d_ready", k), child_ready, vecs[k].exp_ready);
            tick();
            check($sformatf("vec%0d_up_valid", k), up_valid, vecs[k].exp_vld);
            check($sformatf("vec%0d_beat_cnt", k), beat_cnt, vecs[k].exp_cnt);
            if (vecs[k].exp_vld) begin
                check($sformatf("vec%0d_up_idx", k), up_idx, vecs[k].exp_idx);
                check($sformatf("vec%0d_up_data", k), up_data, 32'hA000_0000 + vecs[k].exp_idx);
            end
        end
        child_valid = '0;
        do_clear();

        // ---------------- backpressure ----------------
        up_ready = 1'b0;
        child_valid = 5'b00100;
        set_data(2, 32'h22);
        #1;
        check("bp_first_ready", child_ready, 5'b00100);
        tick();
        set_data(2, 32'h33);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp_hold%0d_ready", k), child_ready, 0);
            tick();
            check($sformatf("bp_hold%0d_data", k), up_data, 32'h22);
            check($sformatf("bp_hold%0d_valid", k), up_valid, 1);
        end
        up_ready = 1'b1;
        #1;
        check("bp_release_ready", child_ready, 5'b00100);
        tick();
        check("bp_second_data", up_data, 32'h33);
        check("bp_cnt_1", beat_cnt, 1);
        child_valid = '0;
        tick();
        check("bp_drained_valid", up_valid, 0);
        check("bp_cnt_2", beat_cnt, 2);
        do_clear();

        // ---------------- last tracking ----------------
        rem  = '{1, 2, 3, 1, 2};
        sent = '{0, 0, 0, 0, 0};
        seq  = '{0, 1, 2, 3, 4, 1, 2, 4, 2};
        exp_done = '0;
        up_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++) begin
                child_valid[i] = (rem[i] > 0);
                child_last[i]  = (rem[i] == 1);
                set_data(i, 32'hB000_0000 | (i << 8) | sent[i]);
            end
            #1;
            g = seq[k];
            check($sformatf("last%0d_ready", k), child_ready, 5'b00001 << g);
            exp_l = (rem[g] == 1);
            tick();
            check($sformatf("last%0d_up_idx", k), up_idx, g);
            check($sformatf("last%0d_up_last", k), up_last, exp_l);
            check($sformatf("last%0d_up_data", k), up_data, 32'hB000_0000 | (g << 8) | sent[g]);
            rem[g]--;
            sent[g]++;
            if (exp_l) exp_done[g] = 1'b1;
            check($sformatf("last%0d_done_mask", k), done_mask, exp_done);
            check($sformatf("last%0d_all_done", k), all_done, 0);
        end
        child_valid = '0;
        child_last  = '0;
        seen_drain  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (all_done) break;
            tick();
            if (dut.r_state == ST_DRAIN) seen_drain = 1'b1;
        end
        check("last_all_done", all_done, 1);
        check("last_seen_drain", seen_drain, 1);
        check("last_beat_cnt", beat_cnt, 9);
        check("last_done_mask", done_mask, 5'b11111);
        child_valid = '1;
        #1;
        check("done_no_ready", child_ready, 0);
        tick();
        check("done_up_valid", up_valid, 0);
        check("done_stays", all_done, 1);
        do_clear();
        check("clear_from_done", all_done, 0);

        // ---------------- clear while draining ----------------
        up_ready   = 1'b1;
        child_last = '1;
        exp_done   = '0;
        for (int k = 0; k < N; k++) begin
            child_valid = ~exp_done;
            #1;
            check($sformatf("dr%0d_ready", k), child_ready, 5'b00001 << k);
            tick();
            exp_done[k] = 1'b1;
        end
        child_valid = '0;
        up_ready    = 1'b0;
        tick();
        check("dr_pending", up_valid, 1);
        check("dr_state", dut.r_state, ST_DRAIN);
        check("dr_cnt_before", beat_cnt, 4);
        clear       = 1'b1;
        child_valid = 5'b01000;
        child_last  = '0;
        set_data(3, 32'h3333);
        #1;
        check("dr_clear_ready", child_ready, 0);
        tick();
        clear = 1'b0;
        check("dr_clear_up_valid", up_valid, 0);
        check("dr_clear_done_mask", done_mask, 0);
        check("dr_clear_beat_cnt", beat_cnt, 0);
        #1;
        check("dr_child3_ready", child_ready, 5'b01000);
        tick();
        check("dr_child3_idx", up_idx, 3);
        check("dr_child3_data", up_data, 32'h3333);
        child_valid = '0;
        do_clear();

        // ---------------- counter saturation ----------------
        up_ready    = 1'b1;
        child_valid = '1;
        child_last  = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("sat%0d_cnt", k), beat_cnt, (k > 15) ? 15 : k);
        end
        tick();
        check("sat_final", beat_cnt, 15);
        child_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hier_fanin_collector.md
Name: hier_fanin_collector

Overview:
- Upward (fan-in) companion to the structural fan-out nodes of the module tree: a parent instantiates N children, and this block collects their result beats back toward the parent.
- Round-robin arbitration over NUM_CHILD valid/ready streams into one registered upstream stream, tagged with the source child index.
- Tracks per-child end-of-stream and reports when every child has finished.
- Sits at each tree node between the child instances and the node's upstream port.

Parameters:
NUM_CHILD, 5, number of child streams (2..8)
DATA_W, 32, payload width per beat
IDX_W, 3, child-index tag width; must satisfy 2**IDX_W >= NUM_CHILD
CNT_W, 16, width of the forwarded-beat counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush and restart of a collection round
child_valid  in  NUM_CHILD  per-child beat valid
child_last  in  NUM_CHILD  per-child final-beat marker, qualified by child_valid
child_data  in  NUM_CHILD*DATA_W  packed payloads; child i occupies bits [i*DATA_W +: DATA_W]
child_ready  out  NUM_CHILD  per-child accept, one-hot or zero
up_valid  out  1  upstream beat valid
up_data  out  DATA_W  upstream payload
up_idx  out  IDX_W  source child of up_data
up_last  out  1  the beat is that child's last
up_ready  in  1  upstream accept
done_mask  out  NUM_CHILD  children whose last beat has been accepted
all_done  out  1  round complete
beat_cnt  out  CNT_W  beats accepted upstream this round

Behaviour:
- Reset (async, rst_n=0): up_valid=0, up_data=0, up_idx=0, up_last=0, done_mask=0, all_done=0, beat_cnt=0, round-robin pointer=0, FSM=IDLE. child_ready=0 while in reset.
- Output slot free = !up_valid || up_ready.
- Eligible child: child_valid[i] && !done_mask[i].
- When the slot is free and FSM is not DONE, grant exactly one eligible child by round-robin: search starts at ptr and wraps modulo NUM_CHILD. Assert child_ready[g] combinationally in the same cycle.
- child_ready may depend on child_valid. Children must hold valid and data until ready.
- On the edge after a grant:
  - up_data, up_idx=g and up_last=child_last[g] are registered; up_valid=1.
  - ptr becomes (g+1) mod NUM_CHILD.
  - If child_last[g] is set, done_mask[g] is set.
- Latency: child handshake to up_valid is 1 cycle. Full throughput of one beat per cycle while up_ready=1.
- No eligible child while the slot is free: up_valid goes to 0 on the next edge, and ptr is unchanged.
- beat_cnt increments on each upstream handshake (up_valid && up_ready) and saturates at 2**CNT_W-1.
- FSM states:
  - IDLE -> COLLECT on the first grant.
  - COLLECT -> DRAIN when done_mask becomes all ones with up_valid still pending.
  - COLLECT/DRAIN -> DONE when done_mask is all ones and up_valid=0. all_done=1 only in DONE.
  - DONE: no grants, all child_ready=0. Stays in DONE until clear.
- clear (highest priority, any state): on the next edge up_valid=0, done_mask=0, beat_cnt=0, ptr=0, FSM=IDLE. A pending upstream beat is discarded. While clear=1, child_ready=0.
- A grant and an upstream accept in the same cycle are legal; the register reloads with no bubble.
- A child sending beats after its last beat stalls (ready low) until clear.

Decomposition:
- Shared package tree_node_pkg: default NUM_CHILD/DATA_W/IDX_W/CNT_W constants, collector FSM state enum (IDLE, COLLECT, DRAIN, DONE).
- Sub-module rr_arbiter (request vector, ptr, enable -> one-hot grant and encoded index). It is purely combinational and reusable by the fan-out side.

Test Plan:
- Reset mid-stream: rst_n low while up_valid=1 with data 0xDEAD -> all outputs return to reset values asynchronously; after release, first grant goes to child 0.
- All five children valid continuously, up_ready=1 -> up_idx sequence 0,1,2,3,4,0,...; one beat per cycle; beat_cnt=10 after 10 cycles.
- Backpressure: up_ready=0 for 4 cycles with child 2 valid (data 0x22) -> up_data holds 0x22, child_ready all 0 after the first capture; nothing is lost or duplicated when up_ready returns.
- Last tracking: children send 1, 2, 3, 1 and 2 beats, each ending with last -> done_mask fills bit by bit; DRAIN precedes DONE; all_done=1 after the 9th upstream handshake; later child_valid gets no ready.
- clear while in DRAIN with a pending beat -> up_valid=0, done_mask=0, beat_cnt=0 next cycle; child 3 valid then gets the first grant after ptr=0 is searched.
- Saturation: CNT_W=4, 20 beats -> beat_cnt stops at 15.
